serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
- Multi-cycle controller that adds two WIDTH-bit operands by sequencing one 2-bit adder instance, 2 bits per cycle, LSB slice first.
- Holds the carry between slices in a register.
- Sits between a requester (start/ready/done handshake) and the 2-bit ripple adder (`adder`, built from two `single_bit_adder`), which it instantiates internally.

Parameters:
- WIDTH, 8, operand/result width in bits; must be even and >= 2 (elaboration error otherwise).
- CNT_W, $clog2(WIDTH/2) (min 1), slice-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; accepted only when ready=1
- a  input  WIDTH  operand A, sampled on accept
- b  input  WIDTH  operand B, sampled on accept
- c_in  input  1  carry-in, sampled on accept
- ready  output  1  high in IDLE only
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse, result valid
- sum  output  WIDTH  registered result
- c_out  output  1  registered final carry-out

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; ready=1; busy=0; done=0; sum=0; c_out=0.
  - Operand shift registers, carry register and slice counter all 0.
- States: IDLE, RUN, DONE (2-bit encoding; unused code -> IDLE).
- IDLE:
  - ready=1.
  - On edge with start=1: load A_sh<=a, B_sh<=b, carry<=c_in, cnt<=0, state<=RUN.
  - start=0: stay.
- RUN:
  - busy=1. Adder inputs are a0/a1 = A_sh[1:0], b0/b1 = B_sh[1:0], c_in = carry.
  - Each edge: acc <= {s1,s0,acc[WIDTH-1:2]}; A_sh, B_sh shift right 2; carry <= adder c_out; cnt++.
  - When cnt == WIDTH/2-1 at an edge: sum <= {s1,s0,acc[WIDTH-1:2]}, c_out <= adder c_out, state <= DONE.
- DONE:
  - done=1 for exactly one cycle.
  - Next edge -> IDLE unconditionally; start during DONE is ignored.
- Latency:
  - Accept edge E0; slices processed at E1..E(WIDTH/2); done high between E(WIDTH/2) and E(WIDTH/2+1).
  - ready returns at E(WIDTH/2+1). For WIDTH=8: done 4 cycles after accept; 6-cycle back-to-back period.
- sum/c_out change only on entry to DONE. They hold through IDLE and the next RUN until the next DONE.
- a, b, c_in are don't-care outside the accept edge; changes during RUN have no effect.
- start while busy or done: ignored, no queuing.
- Arithmetic: {c_out,sum} = a + b + c_in, modulo 2^(WIDTH+1); no overflow flag.
- Reset mid-RUN: operation aborted; outputs return to reset values immediately; no done pulse.
- WIDTH=2: single RUN cycle, cnt stays 0.

Optional Feature:
- Macro: SERIAL_ADD_CTRL_SUB_EN.
- Defined:
  - Extra input port sub (1 bit), sampled on accept.
  - sub=1: B_sh loads ~b and carry loads 1 (c_in ignored), so the result is a - b.
  - c_out=1 means no borrow.
  - sub=0: identical to add behaviour above.
- Undefined: no sub port; add only.

Test Plan:
- WIDTH=8, a=8'h5A, b=8'h3C, c_in=0, start pulse -> done exactly 4 cycles after accept; sum=8'h96, c_out=0; ready back next cycle.
- a=8'hFF, b=8'h01, c_in=0 -> sum=8'h00, c_out=1. Then a=8'hFF, b=8'h00, c_in=1 -> sum=8'h00, c_out=1 (carry chains through all slices).
- start held high continuously with a=8'h01, b=8'h01 -> accepts only in IDLE: done pulses every 6 cycles, sum=8'h02. Changing a/b mid-RUN does not alter the in-flight result.
- Assert rst at the 2nd RUN cycle -> ready=1, busy=0, sum=0, c_out=0 asynchronously; no done. A new op of 8'h10+8'h20 then gives 8'h30.
- SERIAL_ADD_CTRL_SUB_EN defined:
  - 8'h10-8'h01 -> sum=8'h0F, c_out=1.
  - 8'h01-8'h02 -> sum=8'hFF, c_out=0.
  - sub=0 with 8'h5A+8'h3C -> 8'h96.
- Exhaustive sweep with WIDTH=4, all a, b, c_in (512 ops) -> {c_out,sum} matches a+b+c_in every op. The done pulse is always one cycle wide.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Multi-cycle adder: sequences one 2-bit ripple adder over WIDTH-bit operands, LSB slice first.
// Optional macro SERIAL_ADD_CTRL_SUB_EN adds a 'sub' input that turns the operation into a - b.

module single_bit_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);
  assign s     = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module adder (
  input  logic a0,
  input  logic a1,
  input  logic b0,
  input  logic b1,
  input  logic c_in,
  output logic s0,
  output logic s1,
  output logic c_out
);
  logic c_mid;

  single_bit_adder u_bit0 (.a(a0), .b(b0), .c_in(c_in),  .s(s0), .c_out(c_mid));
  single_bit_adder u_bit1 (.a(a1), .b(b1), .c_in(c_mid), .s(s1), .c_out(c_out));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef SERIAL_ADD_CTRL_SUB_EN
  input  logic             sub,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);
  localparam int CNT_W = (WIDTH / 2 > 1) ? $clog2(WIDTH / 2) : 1;

  if ((WIDTH % 2) != 0 || WIDTH < 2) begin : g_bad_width
    $error("serial_add_ctrl: WIDTH must be even and >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_sh_q, b_sh_q, acc_q, sum_q;
  logic              carry_q, c_out_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              add_s0, add_s1, add_c;
  logic [WIDTH-1:0]  acc_d;
  logic [WIDTH-1:0]  b_load;
  logic              c_load;
  logic              last_slice;

`ifdef SERIAL_ADD_CTRL_SUB_EN
  // Subtraction is a + ~b + 1; a final carry of 1 therefore means "no borrow".
  assign b_load = sub ? ~b : b;
  assign c_load = sub ? 1'b1 : c_in;
`else
  assign b_load = b;
  assign c_load = c_in;
`endif

  adder u_adder (
    .a0   (a_sh_q[0]),
    .a1   (a_sh_q[1]),
    .b0   (b_sh_q[0]),
    .b1   (b_sh_q[1]),
    .c_in (carry_q),
    .s0   (add_s0),
    .s1   (add_s1),
    .c_out(add_c)
  );

  // New slice enters at the top so the LSB slice ends up in bits [1:0] after WIDTH/2 steps.
  assign acc_d      = (acc_q >> 2) | (WIDTH'({add_s1, add_s0}) << (WIDTH - 2));
  assign last_slice = (cnt_q == CNT_W'(WIDTH / 2 - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (last_slice) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b_load;
            carry_q <= c_load;
            cnt_q   <= '0;
          end
        end
        S_RUN: begin
          acc_q   <= acc_d;
          a_sh_q  <= a_sh_q >> 2;
          b_sh_q  <= b_sh_q >> 2;
          carry_q <= add_c;
          cnt_q   <= last_slice ? '0 : cnt_q + CNT_W'(1);
          if (last_slice) begin
            sum_q   <= acc_d;
            c_out_q <= add_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum   = sum_q;
  assign c_out = c_out_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: WIDTH=8 scenarios plus an exhaustive WIDTH=4 sweep,
// with a queue-based scoreboard of expected {c_out,sum}.

module tb_serial_add_ctrl;
  logic clk = 1'b0;
  logic rst;

  logic       start8, cin8, ready8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start4, cin4, ready4, busy4, done4, cout4;
  logic [3:0] a4, b4, sum4;
`ifdef SERIAL_ADD_CTRL_SUB_EN
  logic       sub8, sub4;
`endif

  logic [8:0] sb8[$];
  logic [4:0] sb4[$];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .c_in(cin8),
`ifdef SERIAL_ADD_CTRL_SUB_EN
    .sub(sub8),
`endif
    .ready(ready8), .busy(busy8), .done(done8), .sum(sum8), .c_out(cout8)
  );

  serial_add_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .c_in(cin4),
`ifdef SERIAL_ADD_CTRL_SUB_EN
    .sub(sub4),
`endif
    .ready(ready4), .busy(busy4), .done(done4), .sum(sum4), .c_out(cout4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready8(input string tag);
    int n = 0;
    while (ready8 !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, " ready"}, 32'(ready8), 32'd1);
  endtask

  // One WIDTH=8 operation: accept, latency, result, and ready/done after the pulse.
  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                     input logic sv, input string tag);
    int lat;
    logic [8:0] exp;
    wait_ready8(tag);
    a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
`ifdef SERIAL_ADD_CTRL_SUB_EN
    sub8 = sv;
`endif
    @(posedge clk);
    if (sv) exp = {1'b0, av} + {1'b0, ~bv} + 9'd1;
    else    exp = {1'b0, av} + {1'b0, bv} + {8'd0, cv};
    sb8.push_back(exp);
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    lat = 0;
    while (done8 !== 1'b1 && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'd4);
    check({tag, " result"}, {23'd0, cout8, sum8}, {23'd0, sb8.pop_front()});
    @(negedge clk);
    check({tag, " ready after done"}, 32'(ready8), 32'd1);
    check({tag, " done width"}, 32'(done8), 32'd0);
  endtask

  initial begin
    int last_done, npulse, ndone, n, lat;
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
`ifdef SERIAL_ADD_CTRL_SUB_EN
    sub8 = 1'b0; sub4 = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    check("reset ready", 32'(ready8), 32'd1);
    check("reset busy",  32'(busy8),  32'd0);
    check("reset done",  32'(done8),  32'd0);
    check("reset sum",   32'(sum8),   32'd0);
    check("reset c_out", 32'(cout8),  32'd0);
    rst = 1'b0;
    @(negedge clk);

    op8(8'h5A, 8'h3C, 1'b0, 1'b0, "add 5A+3C");
    op8(8'hFF, 8'h01, 1'b0, 1'b0, "add FF+01");
    op8(8'hFF, 8'h00, 1'b1, 1'b0, "add FF+00+1");
    op8(8'hA5, 8'h5A, 1'b1, 1'b0, "add A5+5A+1");

    // start held high: accepts only in IDLE, mid-run operand changes are ignored.
    wait_ready8("held");
    a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    last_done = -1; npulse = 0;
    for (int t = 0; t < 20; t++) begin
      if (ready8) begin
        a8 = 8'h01; b8 = 8'h01;
        sb8.push_back(9'h002);
      end else begin
        a8 = 8'($urandom); b8 = 8'($urandom);
      end
      if (done8 && sb8.size() > 0) begin
        check("held result", {23'd0, cout8, sum8}, {23'd0, sb8.pop_front()});
        if (last_done >= 0) check("held period", 32'(t - last_done), 32'd6);
        last_done = t;
        npulse++;
      end
      @(negedge clk);
    end
    start8 = 1'b0;
    check("held pulse count", 32'(npulse), 32'd3);
    n = 0;
    while (sb8.size() > 0 && n < 12) begin
      if (done8) check("held drain", {23'd0, cout8, sum8}, {23'd0, sb8.pop_front()});
      @(negedge clk);
      n++;
    end
    check("held queue empty", 32'(sb8.size()), 32'd0);

    // Asynchronous reset in the second RUN cycle aborts the operation.
    wait_ready8("abort");
    a8 = 8'h77; b8 = 8'h11; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    check("abort busy before rst", 32'(busy8), 32'd1);
    rst = 1'b1;
    #1;
    check("abort ready", 32'(ready8), 32'd1);
    check("abort busy",  32'(busy8),  32'd0);
    check("abort sum",   32'(sum8),   32'd0);
    check("abort c_out", 32'(cout8),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    check("abort no done", 32'(ndone), 32'd0);
    op8(8'h10, 8'h20, 1'b0, 1'b0, "after abort 10+20");

`ifdef SERIAL_ADD_CTRL_SUB_EN
    op8(8'h10, 8'h01, 1'b0, 1'b1, "sub 10-01");
    op8(8'h01, 8'h02, 1'b1, 1'b1, "sub 01-02");
    op8(8'h5A, 8'h3C, 1'b0, 1'b0, "sub=0 5A+3C");
`endif

    // Exhaustive WIDTH=4 sweep.
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          n = 0;
          while (ready4 !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
          end
          a4 = 4'(ai); b4 = 4'(bi); cin4 = 1'(ci); start4 = 1'b1;
          @(posedge clk);
          sb4.push_back(5'(ai + bi + ci));
          @(negedge clk);
          start4 = 1'b0;
          a4 = 4'($urandom); b4 = 4'($urandom);
          lat = 0;
          while (done4 !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
          end
          check("sweep result", {27'd0, cout4, sum4}, {27'd0, sb4.pop_front()});
          @(negedge clk);
          check("sweep done width", 32'(done4), 32'd0);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
